jimmy_fetch_unit: RTL and testbench

- Instruction fetch stage for the Jimmy 8-bit CPU. It sits directly downstream of the program memory.
- Drives the 8-bit program address bus and captures the opcode byte, plus the immediate/target byte for two-byte instructions.
- Presents one complete instruction to the execute stage through a valid/ready handshake.
- Handles PC increment, PC wrap-around and branch redirection.

---
 rtl/jimmy_fetch_unit.sv | 86 ++++++++
 tb/tb_jimmy_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jimmy_fetch_unit.sv
// Jimmy 8-bit CPU instruction fetch stage.
// Fetches one- or two-byte instructions and hands them to execute.
module jimmy_fetch_unit #(
   parameter logic [7:0] RESET_VECTOR = 8'd0,
   parameter logic [7:0] NOP_CODE     = 8'h70
) (
   input  logic       program_clk,
   input  logic       reset,
   output logic [7:0] address_bus,
   input  logic [7:0] data_bus,
   output logic [7:0] instr,
   output logic [7:0] operand,
   output logic       instr_valid,
   input  logic       exec_ready,
   input  logic       branch_take,
   input  logic [7:0] branch_target
);

   localparam logic [1:0] FETCH_OP  = 2'd0;
   localparam logic [1:0] FETCH_IMM = 2'd1;
   localparam logic [1:0] HOLD      = 2'd2;

   logic [1:0] state;
   logic [7:0] pc;
   logic [7:0] instr_q;
   logic [7:0] operand_q;
   logic       valid_q;
   logic       two_byte;
   logic       accept;

   // Length decode of the byte currently on the bus
   always_comb begin
      two_byte = data_bus[7] & (data_bus[5] | ~data_bus[4]);
      accept   = valid_q & exec_ready;
   end

   // Fetch sequencer: opcode, optional immediate, then hold until accepted
   always_ff @(posedge program_clk or negedge reset) begin
      if (!reset) begin
         state     <= FETCH_OP;
         pc        <= RESET_VECTOR;
         instr_q   <= NOP_CODE;
         operand_q <= 8'd0;
         valid_q   <= 1'b0;
      end else begin
         case (state)
            FETCH_OP: begin
               instr_q   <= data_bus;
               operand_q <= 8'd0;
               pc        <= pc + 8'd1;
               if (two_byte) begin
                  state <= FETCH_IMM;
               end else begin
                  state   <= HOLD;
                  valid_q <= 1'b1;
               end
            end
            FETCH_IMM: begin
               operand_q <= data_bus;
               pc        <= pc + 8'd1;
               state     <= HOLD;
               valid_q   <= 1'b1;
            end
            HOLD: begin
               if (accept) begin
                  valid_q <= 1'b0;
                  state   <= FETCH_OP;
                  if (branch_take) begin
                     pc <= branch_target;
                  end
               end
            end
            default: begin
               state   <= FETCH_OP;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign address_bus = pc;
   assign instr       = instr_q;
   assign operand     = operand_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_jimmy_fetch_unit.sv
// Self-checking bench for jimmy_fetch_unit.
// Directed scenarios followed by a randomized transaction-level run.
module tb_jimmy_fetch_unit;

   logic       clk;
   logic       reset;

   logic [7:0] rom0 [256];
   logic [7:0] rom1 [256];

   logic [7:0] addr0, data0, instr0, op0, tgt0;
   logic       valid0, ready0, bt0;
   logic [7:0] addr1, data1, instr1, op1, tgt1;
   logic       valid1, ready1, bt1;

   int checks = 0;
   int errors = 0;

   assign data0 = rom0[addr0];
   assign data1 = rom1[addr1];

   jimmy_fetch_unit u0 (
      .program_clk   (clk),
      .reset         (reset),
      .address_bus   (addr0),
      .data_bus      (data0),
      .instr         (instr0),
      .operand       (op0),
      .instr_valid   (valid0),
      .exec_ready    (ready0),
      .branch_take   (bt0),
      .branch_target (tgt0)
   );

   jimmy_fetch_unit #(.RESET_VECTOR(8'hFF)) u1 (
      .program_clk   (clk),
      .reset         (reset),
      .address_bus   (addr1),
      .data_bus      (data1),
      .instr         (instr1),
      .operand       (op1),
      .instr_valid   (valid1),
      .exec_ready    (ready1),
      .branch_take   (bt1),
      .branch_target (tgt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] a,
                          input logic [7:0] i, input logic [7:0] o,
                          input logic v);
      chk({tag, ".addr"}, addr0, a);
      chk({tag, ".instr"}, instr0, i);
      chk({tag, ".operand"}, op0, o);
      chk({tag, ".valid"}, {7'd0, valid0}, {7'd0, v});
   endtask

   function automatic int ilen(input logic [7:0] b);
      // Two-byte: LD_IMM, CMP_IMM and the branch group
      if (b[7:3] == 5'b10100 || b[7:3] == 5'b10101 ||
          b[7:3] == 5'b10110 || b[7:3] == 5'b10111 ||
          b[7:3] == 5'b10000 || b[7:3] == 5'b10001 ||
          b[7:3] == 5'b11100 || b[7:3] == 5'b11101 ||
          b[7:3] == 5'b11110 || b[7:3] == 5'b11111 ||
          b[7:3] == 5'b11000 || b[7:3] == 5'b11001)
         return 2;
      return 1;
   endfunction

   initial begin
      logic [7:0] p, nxt, opc, opd, tg;
      int len, stalls;
      logic b;

      foreach (rom0[i]) rom0[i] = 8'h00;
      foreach (rom1[i]) rom1[i] = 8'h00;
      rom0[0] = 8'h98;
      rom0[1] = 8'h8C;
      rom0[2] = 8'h01;
      rom0[3] = 8'hB0;
      rom0[4] = 8'h09;
      rom0[5] = 8'h80;
      rom0[6] = 8'h55;
      rom0[9] = 8'h20;
      rom1[255] = 8'h80;
      rom1[0]   = 8'h2A;

      reset = 1'b0;
      ready0 = 1'b0; bt0 = 1'b0; tgt0 = 8'h00;
      ready1 = 1'b0; bt1 = 1'b0; tgt1 = 8'h00;

      // Reset / idle
      tick();
      tick();
      chk_out("rst", 8'h00, 8'h70, 8'h00, 1'b0);
      chk("rst.addr1", addr1, 8'hFF);
      reset = 1'b1;
      tick();
      chk_out("first", 8'h01, 8'h98, 8'h00, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out("stall", 8'h01, 8'h98, 8'h00, 1'b1);
      end

      // Two-byte fetch with ready held high
      ready0 = 1'b1;
      tick();
      chk_out("acc1", 8'h01, 8'h98, 8'h00, 1'b0);
      tick();
      chk_out("imm", 8'h02, 8'h8C, 8'h00, 1'b0);
      bt0 = 1'b1; tgt0 = 8'h40;
      tick();
      chk_out("cmp", 8'h03, 8'h8C, 8'h01, 1'b1);
      bt0 = 1'b0;
      tick();
      chk_out("acc2", 8'h03, 8'h8C, 8'h01, 1'b0);

      // Branch ignored while stalled, taken on accept
      ready0 = 1'b0;
      tick();
      tick();
      chk_out("br", 8'h05, 8'hB0, 8'h09, 1'b1);
      bt0 = 1'b1; tgt0 = 8'h40;
      tick();
      tick();
      chk_out("brstall", 8'h05, 8'hB0, 8'h09, 1'b1);
      tgt0 = 8'h09; ready0 = 1'b1;
      tick();
      chk_out("brtake", 8'h09, 8'hB0, 8'h09, 1'b0);
      bt0 = 1'b0; ready0 = 1'b0;
      tick();
      chk_out("tgt", 8'h0A, 8'h20, 8'h00, 1'b1);

      // Same branch accepted with branch_take=0
      ready0 = 1'b1; bt0 = 1'b1; tgt0 = 8'h03;
      tick();
      chk("back.addr", addr0, 8'h03);
      bt0 = 1'b0; ready0 = 1'b0;
      tick();
      tick();
      ready0 = 1'b1;
      tick();
      chk_out("nobr", 8'h05, 8'hB0, 8'h09, 1'b0);

      // Async reset in FETCH_IMM
      ready0 = 1'b0;
      tick();
      chk_out("pre", 8'h06, 8'h80, 8'h00, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk_out("arst", 8'h00, 8'h70, 8'h00, 1'b0);
      #1 reset = 1'b1;
      tick();
      chk_out("restart", 8'h01, 8'h98, 8'h00, 1'b1);

      // Wrap-around on the 0xFF-vector instance
      #2 reset = 1'b0;
      #1 reset = 1'b1;
      chk("wrap.rv", addr1, 8'hFF);
      tick();
      chk("wrap.addr0", addr1, 8'h00);
      tick();
      chk("wrap.instr", instr1, 8'h80);
      chk("wrap.op", op1, 8'h2A);
      chk("wrap.valid", {7'd0, valid1}, 8'd1);
      chk("wrap.addr1", addr1, 8'h01);
      ready1 = 1'b1;
      tick();
      chk("wrap.acc", addr1, 8'h01);
      chk("wrap.accv", {7'd0, valid1}, 8'd0);
      ready1 = 1'b0;

      // Randomized run against an instruction-level model
      foreach (rom0[i]) rom0[i] = 8'($urandom);
      #2 reset = 1'b0;
      ready0 = 1'b0; bt0 = 1'b0;
      #1 reset = 1'b1;
      p = 8'h00;
      for (int n = 0; n < 250; n++) begin
         opc = rom0[p];
         len = ilen(opc);
         opd = (len == 2) ? rom0[8'(p + 8'd1)] : 8'h00;
         ready0 = 1'($urandom); bt0 = 1'($urandom);
         tgt0 = 8'($urandom);
         tick();
         if (len == 2) begin
            chk("rnd.fimm.v", {7'd0, valid0}, 8'd0);
            chk("rnd.fimm.a", addr0, 8'(p + 8'd1));
            ready0 = 1'($urandom); bt0 = 1'($urandom);
            tgt0 = 8'($urandom);
            tick();
         end
         chk_out("rnd.hold", 8'(p + 8'(len)), opc, opd, 1'b1);
         stalls = $urandom_range(0, 2);
         for (int s = 0; s < stalls; s++) begin
            ready0 = 1'b0; bt0 = 1'($urandom);
            tgt0 = 8'($urandom);
            tick();
            chk_out("rnd.stall", 8'(p + 8'(len)), opc, opd, 1'b1);
         end
         b = 1'($urandom);
         tg = 8'($urandom);
         ready0 = 1'b1; bt0 = b; tgt0 = tg;
         tick();
         nxt = b ? tg : 8'(p + 8'(len));
         chk("rnd.acc.v", {7'd0, valid0}, 8'd0);
         chk("rnd.acc.a", addr0, nxt);
         p = nxt;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
